// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
// Serial-receiver bus: the RX line and consumer handshake in, received byte and status flags out.
interface uart_rx_if;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  RX,
    input  clr_rdy,
    output rx_data,
    output rdy,
    output frame_err,
    output overrun
  );

  modport slave (
    output RX,
    output clr_rdy,
    input  rx_data,
    input  rdy,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver with mid-bit sampling, sticky rdy/frame_err/overrun flags and a
// post-reset/post-break hunt for a full bit time of idle line before accepting a start bit.
module uart_rx #(
  parameter int unsigned BAUD_DIV = 2605,
  parameter int unsigned HALF     = BAUD_DIV / 2
) (
  input logic       clk,
  input logic       rst_n,
  uart_rx_if.master bus
);

  typedef enum logic [2:0] {StHunt, StIdle, StStart, StData, StStop} state_e;

  localparam logic [12:0] BaudLoad = 13'(BAUD_DIV - 1);
  localparam logic [12:0] HalfLoad = 13'(HALF - 1);

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_sync_q;
  logic [12:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rdy_q, rdy_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        tick;
  logic        good_frame, bad_frame;

  // Two-flop synchronizer, preset high so reset looks like an idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign tick = (baud_cnt_q == 13'd0) && (state_q inside {StStart, StData, StStop});

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
    case (state_q)
      // Counter runs upward here, counting consecutive high samples.
      StHunt: begin
        if (!rx_sync_q) begin
          baud_cnt_d = 13'd0;
        end else if (baud_cnt_q == BaudLoad) begin
          baud_cnt_d = 13'd0;
          state_d    = StIdle;
        end else begin
          baud_cnt_d = baud_cnt_q + 13'd1;
        end
      end
      StIdle: begin
        if (!rx_sync_q) begin
          state_d    = StStart;
          baud_cnt_d = HalfLoad;
          bit_cnt_d  = 4'd0;
        end
      end
      StStart: begin
        if (tick) begin
          baud_cnt_d = BaudLoad;
          state_d    = rx_sync_q ? StIdle : StData;
        end else begin
          baud_cnt_d = baud_cnt_q - 13'd1;
        end
      end
      StData: begin
        if (tick) begin
          baud_cnt_d = BaudLoad;
          shift_d    = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = StStop;
        end else begin
          baud_cnt_d = baud_cnt_q - 13'd1;
        end
      end
      StStop: begin
        if (tick) begin
          if (rx_sync_q) begin
            good_frame = 1'b1;
            baud_cnt_d = BaudLoad;
            state_d    = StIdle;
          end else begin
            bad_frame  = 1'b1;
            baud_cnt_d = 13'd0;
            state_d    = StHunt;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 13'd1;
        end
      end
      default: begin
        state_d    = StHunt;
        baud_cnt_d = 13'd0;
      end
    endcase
  end

  // Set beats clear; a coincident clr_rdy consumes the old byte so no overrun.
  always_comb begin
    rx_data_d   = rx_data_q;
    rdy_d       = bus.clr_rdy ? 1'b0 : rdy_q;
    frame_err_d = bus.clr_rdy ? 1'b0 : frame_err_q;
    overrun_d   = bus.clr_rdy ? 1'b0 : overrun_q;
    if (good_frame) begin
      rx_data_d = shift_q;
      rdy_d     = 1'b1;
      overrun_d = !bus.clr_rdy && (overrun_q || rdy_q);
    end
    if (bad_frame) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      baud_cnt_q  <= 13'd0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Directed bench for uart_rx: one receiver at 16 clk/bit, one at the default 2605 clk/bit.
module tb_uart_rx;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  uart_rx_if bus16 ();
  uart_rx_if bus_def ();

  uart_rx #(.BAUD_DIV(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus16));
  uart_rx u_dut_def (.clk(clk), .rst_n(rst_n), .bus(bus_def));

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_of(input bit sel);
    return sel ? bus_def.rdy : bus16.rdy;
  endfunction

  task automatic drive(input bit sel, input logic rx, input logic clr);
    if (sel) begin
      bus_def.RX = rx;
      bus_def.clr_rdy = clr;
    end else begin
      bus16.RX = rx;
      bus16.clr_rdy = clr;
    end
  endtask

  task automatic pulse_clr16();
    bus16.clr_rdy = 1'b1;
    step(1);
    bus16.clr_rdy = 1'b0;
  endtask

  // Drives one frame; rdy_at is the cycle (after the start edge) at which rdy was seen to rise.
  task automatic send_frame(input bit sel, input int div, input logic [7:0] b, input logic stop,
                            input int clr_at, output int rdy_at);
    logic prev, rx;
    int   bit_idx;
    rdy_at = -1;
    prev   = rdy_of(sel);
    for (int c = 0; c < 10 * div; c++) begin
      bit_idx = c / div;
      if (bit_idx == 0) rx = 1'b0;
      else if (bit_idx == 9) rx = stop;
      else rx = b[bit_idx-1];
      drive(sel, rx, c == clr_at);
      step(1);
      if (rdy_at < 0 && !prev && rdy_of(sel)) rdy_at = c + 1;
      prev = rdy_of(sel);
    end
    drive(sel, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    step(3);
    checks++;
    if (bus16.rdy !== 1'b0) begin
      failures++; $display("FAIL reset_rdy: got %b want 0", bus16.rdy);
    end
    checks++;
    if (bus16.frame_err !== 1'b0) begin
      failures++; $display("FAIL reset_frame_err: got %b want 0", bus16.frame_err);
    end
    checks++;
    if (bus16.overrun !== 1'b0) begin
      failures++; $display("FAIL reset_overrun: got %b want 0", bus16.overrun);
    end
    checks++;
    if (bus16.rx_data !== 8'h00) begin
      failures++; $display("FAIL reset_rx_data: got %h want 00", bus16.rx_data);
    end
    checks++;
    if (bus_def.rdy !== 1'b0) begin
      failures++; $display("FAIL reset_def_rdy: got %b want 0", bus_def.rdy);
    end
    rst_n = 1'b1;
    step(20);
  endtask

  task automatic test_basic();
    int rdy_at;
    send_frame(1'b0, 16, 8'hA5, 1'b1, -1, rdy_at);
    checks++;
    if (bus16.rx_data !== 8'hA5) begin
      failures++; $display("FAIL basic_data: got %h want a5", bus16.rx_data);
    end
    checks++;
    if (bus16.rdy !== 1'b1) begin
      failures++; $display("FAIL basic_rdy: got %b want 1", bus16.rdy);
    end
    checks++;
    if (rdy_at < 152 || rdy_at > 158) begin
      failures++; $display("FAIL basic_latency: got %0d want 155+-3", rdy_at);
    end
    pulse_clr16();
    checks++;
    if (bus16.rdy !== 1'b0) begin
      failures++; $display("FAIL basic_clr: got %b want 0", bus16.rdy);
    end
  endtask

  task automatic test_glitch();
    int rdy_at;
    bus16.RX = 1'b0;
    step(4);
    bus16.RX = 1'b1;
    step(40);
    checks++;
    if (bus16.rdy !== 1'b0 || bus16.frame_err !== 1'b0) begin
      failures++;
      $display("FAIL glitch_flags: got rdy=%b ferr=%b want 0 0", bus16.rdy, bus16.frame_err);
    end
    send_frame(1'b0, 16, 8'h3C, 1'b1, -1, rdy_at);
    checks++;
    if (bus16.rx_data !== 8'h3C || bus16.rdy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_next: got %h/%b want 3c/1", bus16.rx_data, bus16.rdy);
    end
    checks++;
    if (rdy_at < 152 || rdy_at > 158) begin
      failures++; $display("FAIL glitch_latency: got %0d want 155+-3", rdy_at);
    end
    pulse_clr16();
  endtask

  task automatic test_frame_err();
    int rdy_at;
    // clr_rdy lands on the stop sample: the error must still be flagged.
    send_frame(1'b0, 16, 8'h81, 1'b0, 154, rdy_at);
    checks++;
    if (bus16.frame_err !== 1'b1) begin
      failures++; $display("FAIL ferr_set: got %b want 1", bus16.frame_err);
    end
    checks++;
    if (bus16.rdy !== 1'b0 || bus16.rx_data !== 8'h3C) begin
      failures++;
      $display("FAIL ferr_hold: got %b/%h want 0/3c", bus16.rdy, bus16.rx_data);
    end
    bus16.RX = 1'b0;
    step(100);
    checks++;
    if (bus16.rdy !== 1'b0 || bus16.frame_err !== 1'b1) begin
      failures++;
      $display("FAIL break_quiet: got rdy=%b ferr=%b want 0 1", bus16.rdy, bus16.frame_err);
    end
    bus16.RX = 1'b1;
    step(20);
    send_frame(1'b0, 16, 8'h7E, 1'b1, -1, rdy_at);
    checks++;
    if (bus16.rdy !== 1'b1 || bus16.rx_data !== 8'h7E) begin
      failures++;
      $display("FAIL break_next: got %b/%h want 1/7e", bus16.rdy, bus16.rx_data);
    end
    pulse_clr16();
    checks++;
    if (bus16.frame_err !== 1'b0 || bus16.rdy !== 1'b0) begin
      failures++;
      $display("FAIL ferr_clr: got ferr=%b rdy=%b want 0 0", bus16.frame_err, bus16.rdy);
    end
  endtask

  task automatic test_overrun();
    int rdy_at;
    send_frame(1'b0, 16, 8'h11, 1'b1, -1, rdy_at);
    send_frame(1'b0, 16, 8'h22, 1'b1, -1, rdy_at);
    checks++;
    if (bus16.rx_data !== 8'h22 || bus16.overrun !== 1'b1 || bus16.rdy !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set: got %h/%b/%b want 22/1/1", bus16.rx_data, bus16.overrun,
               bus16.rdy);
    end
    pulse_clr16();
    checks++;
    if (bus16.overrun !== 1'b0) begin
      failures++; $display("FAIL ovr_clr: got %b want 0", bus16.overrun);
    end
    send_frame(1'b0, 16, 8'h44, 1'b1, -1, rdy_at);
    checks++;
    if (bus16.overrun !== 1'b0 || bus16.rdy !== 1'b1) begin
      failures++; $display("FAIL ovr_single: got %b/%b want 0/1", bus16.overrun, bus16.rdy);
    end
    send_frame(1'b0, 16, 8'h55, 1'b1, 154, rdy_at);
    checks++;
    if (bus16.rdy !== 1'b1 || bus16.overrun !== 1'b0 || bus16.rx_data !== 8'h55) begin
      failures++;
      $display("FAIL ovr_coincident: got %b/%b/%h want 1/0/55", bus16.rdy, bus16.overrun,
               bus16.rx_data);
    end
  endtask

  task automatic test_reset_midframe();
    int rdy_at;
    logic [7:0] b;
    int bit_idx;
    b = 8'hE7;
    for (int c = 0; c < 88; c++) begin
      bit_idx = c / 16;
      bus16.RX = (bit_idx == 0) ? 1'b0 : b[bit_idx-1];
      step(1);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus16.RX = ~bus16.RX;
      step(1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus16.RX = ~bus16.RX;
      step(1);
    end
    bus16.RX = 1'b1;
    checks++;
    if (bus16.rdy !== 1'b0 || bus16.frame_err !== 1'b0 || bus16.overrun !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_flags: got %b%b%b want 000", bus16.rdy, bus16.frame_err,
               bus16.overrun);
    end
    checks++;
    if (bus16.rx_data !== 8'h00) begin
      failures++; $display("FAIL rst_mid_data: got %h want 00", bus16.rx_data);
    end
    step(20);
    send_frame(1'b0, 16, 8'hE7, 1'b1, -1, rdy_at);
    checks++;
    if (bus16.rdy !== 1'b1 || bus16.rx_data !== 8'hE7) begin
      failures++;
      $display("FAIL rst_mid_next: got %b/%h want 1/e7", bus16.rdy, bus16.rx_data);
    end
    pulse_clr16();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    int rdy_at;
    bytes = '{8'h00, 8'hFF, 8'h5A, 8'hC3};
    for (int i = 0; i < 4; i++) begin
      send_frame(1'b0, 16, bytes[i], 1'b1, 157, rdy_at);
      checks++;
      if (bus16.rx_data !== bytes[i]) begin
        failures++; $display("FAIL b2b_data[%0d]: got %h want %h", i, bus16.rx_data, bytes[i]);
      end
      checks++;
      if (rdy_at < 152 || rdy_at > 158) begin
        failures++; $display("FAIL b2b_latency[%0d]: got %0d want 155+-3", i, rdy_at);
      end
      checks++;
      if (bus16.frame_err !== 1'b0 || bus16.overrun !== 1'b0 || bus16.rdy !== 1'b0) begin
        failures++;
        $display("FAIL b2b_flags[%0d]: got ferr=%b ovr=%b rdy=%b want 0 0 0", i,
                 bus16.frame_err, bus16.overrun, bus16.rdy);
      end
    end
  endtask

  task automatic test_default_baud();
    logic [7:0] bytes [2];
    int rdy_at;
    bytes = '{8'h5A, 8'hC3};
    step(2700);
    // 3 + 1302 + 9*2605
    for (int i = 0; i < 2; i++) begin
      send_frame(1'b1, 2605, bytes[i], 1'b1, 24760, rdy_at);
      checks++;
      if (bus_def.rx_data !== bytes[i]) begin
        failures++;
        $display("FAIL def_data[%0d]: got %h want %h", i, bus_def.rx_data, bytes[i]);
      end
      checks++;
      if (rdy_at < 24747 || rdy_at > 24753) begin
        failures++; $display("FAIL def_latency[%0d]: got %0d want 24750+-3", i, rdy_at);
      end
      checks++;
      if (bus_def.frame_err !== 1'b0 || bus_def.overrun !== 1'b0) begin
        failures++;
        $display("FAIL def_flags[%0d]: got ferr=%b ovr=%b want 0 0", i, bus_def.frame_err,
                 bus_def.overrun);
      end
    end
  endtask

  initial begin
    bus16.RX = 1'b1;
    bus16.clr_rdy = 1'b0;
    bus_def.RX = 1'b1;
    bus_def.clr_rdy = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    test_default_baud();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver: 8N1 frame (start, 8 data bits LSB first, 1 stop), line idles high.
- Sits downstream of the team's UART transmitter, either across the link or in loopback. Consumes the serial TX line and presents completed bytes with a ready flag.
- Default bit period matches the transmitter exactly: 2605 clk per bit.

Parameters:
- BAUD_DIV, 2605: clk cycles per bit; legal range 8..8191.
- HALF, BAUD_DIV/2 (integer division): delay from start-bit detect to its mid-bit sample.

Ports:
- clk  input  1  system clock; all flops on posedge.
- rst_n  input  1  asynchronous active-low reset.
- RX  input  1  asynchronous serial line; idles high.
- clr_rdy  input  1  single-cycle pulse; consumer acknowledges the byte and clears the flags.
- rx_data  output  8  last good received byte; holds until the next good frame.
- rdy  output  1  byte valid; sticky until clr_rdy.
- frame_err  output  1  stop bit sampled low; sticky until clr_rdy.
- overrun  output  1  good byte completed while rdy already set; sticky until clr_rdy.

Behaviour:
- Reset values: rx_data=8'h00, rdy=0, frame_err=0, overrun=0, state=HUNT.
- Synchronizer flops are preset to 1; baud and bit counters are cleared.
- Reset mid-frame aborts the frame; no flag is set.
- RX passes through 2 flops (rx_sync); only rx_sync is used internally.
- Baud counter: 13-bit down-counter.
  - "tick" = counter==0 while in START/DATA/STOP.
  - On tick it reloads BAUD_DIV-1; otherwise it decrements.
- Bit counter: 4 bits; counts DATA samples 0..8.
- HUNT: waits for rx_sync==1 for BAUD_DIV consecutive cycles.
  - Uses the baud counter; any 0 restarts the count.
  - When the count completes -> IDLE.
  - Guarantees no false start after reset or a break.
- IDLE: rx_sync==0 -> START, baud counter loaded with HALF-1, bit counter cleared.
- START: on tick, sample rx_sync.
  - 1 -> IDLE (glitch rejected, no flags).
  - 0 -> DATA.
- DATA: on each tick, shift rx_sync into shift-reg MSB (shift right) and increment the bit counter.
  - After the 8th sample -> STOP.
  - Shift reg bit0 = first data bit.
- STOP: on tick, sample rx_sync.
  - 1 (good frame): rx_data<=shift reg; rdy<=1; overrun<=1 if rdy was already 1; -> IDLE.
  - 0 (bad frame): frame_err<=1; rx_data and rdy unchanged; -> HUNT.
- Sample point: mid-bit. The stop sample occurs HALF+9*BAUD_DIV cycles after IDLE exits (±1).
- Latency: rdy rises 1 cycle after the stop sample, i.e. ≈ 3+HALF+9*BAUD_DIV cycles after the RX falling edge. Benches allow ±3.
- clr_rdy clears rdy, frame_err and overrun next cycle.
- clr_rdy coincident with a good-frame completion: rdy=1, overrun=0 (set wins for rdy; old byte counts as consumed).
- clr_rdy coincident with a frame error: frame_err=1.
- clr_rdy is ignored for state sequencing; reception is never stalled. Back-to-back frames with no idle gap are supported (stop-bit sample at mid-bit leaves half a bit to detect the next start).
- Overrun: the newest good byte always overwrites rx_data.
- Bit and baud counters never wrap in normal operation. The baud counter reloads on tick before reaching underflow.

Test Plan:
- Reset with RX=1, BAUD_DIV=16: all outputs 0. After 16+ idle cycles, send 8'hA5 -> rx_data=8'hA5, rdy=1 about 3+8+144 cycles after the start edge (±3). Then clr_rdy pulse -> rdy=0 next cycle.
- Loopback with the transmitter at default (2605): send 8'h00, 8'hFF, 8'h5A, 8'hC3 back-to-back, clr_rdy after each. Each rx_data matches, frame_err=0, overrun=0.
- BAUD_DIV=16: RX low for 4 cycles, then high -> START rejects at the mid sample, no rdy, state returns to IDLE. A following valid 8'h3C is received correctly.
- BAUD_DIV=16: frame 8'h81 with stop bit forced low -> frame_err=1, rdy=0, rx_data unchanged. Line held low 100 cycles (break) -> no new frame until RX high ≥16 cycles. Then 8'h7E -> rdy=1, rx_data=8'h7E.
- BAUD_DIV=16: receive 8'h11, no clr_rdy, then 8'h22 -> rx_data=8'h22, overrun=1. Repeat with clr_rdy asserted the exact cycle rdy would be set -> rdy=1, overrun=0.
- BAUD_DIV=16: assert rst_n low during data bit 4 of a frame, release while RX still toggling -> no rdy or flags. Receiver waits for 16 high cycles, then receives the next 8'hE7 correctly.
